rom_word_serializer: RTL and testbench

- Downstream consumer of the tag ROM interface.
- Takes 16-bit words that the ROM interface has latched and presents, one at a time, with a word-level ready/ack handshake.
- Shifts each word out MSB-first as a serial bit stream to the backscatter encoder.
- Counts words against the requested word count and signals completion. Optionally appends a Gen2-style CRC-16.

---
 rtl/rom_word_serializer.sv | 140 ++++++++++++++
 tb/tb_rom_word_serializer.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_word_serializer.sv
// Serialises 16-bit ROM words MSB-first toward the backscatter encoder.
// Define ROM_SER_CRC16_EN to append the inverted CRC-16/CCITT after the data.
module rom_word_serializer #(
  parameter int WORD_W = 16,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [CNT_W-1:0]  i_wordcnt,
  input  logic              i_abort,
  input  logic [WORD_W-1:0] i_word,
  input  logic              i_word_vld,
  output logic              o_word_ack,
  output logic              o_bit,
  output logic              o_bit_vld,
  input  logic              i_bit_rdy,
  output logic              o_busy,
  output logic              o_done
);

  localparam int BC_W = $clog2(WORD_W);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd4;
`ifdef ROM_SER_CRC16_EN
  localparam logic [2:0] S_CRC   = 3'd3;
`endif

  logic [2:0]        state;
  logic [WORD_W-1:0] shreg;
  logic [BC_W-1:0]   bitcnt;
  logic [CNT_W-1:0]  words_left;
  logic              word_ack;
  logic              bit_vld;
  logic              last_bit;

`ifdef ROM_SER_CRC16_EN
  localparam logic [2:0] S_OUT_CRC = S_CRC;
  logic [15:0] crc;
  logic [15:0] crc_nxt;
  logic        fb;

  always_comb begin
    fb      = crc[15] ^ shreg[WORD_W-1];
    crc_nxt = {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  end
`endif

`ifdef ROM_SER_CRC16_EN
  assign bit_vld = (state == S_SHIFT) || (state == S_CRC);
`else
  assign bit_vld = (state == S_SHIFT);
`endif
  assign last_bit = (bitcnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      shreg      <= '0;
      bitcnt     <= '0;
      words_left <= '0;
      word_ack   <= 1'b0;
`ifdef ROM_SER_CRC16_EN
      crc        <= '0;
`endif
    end else begin
      word_ack <= 1'b0;
      if (i_abort) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: if (i_start) begin
            words_left <= i_wordcnt;
`ifdef ROM_SER_CRC16_EN
            crc <= 16'hFFFF;
`endif
            if (i_wordcnt != '0) begin
              state <= S_WAIT;
            end else begin
`ifdef ROM_SER_CRC16_EN
              // Empty transfer still sends the checksum of nothing: ~0xFFFF.
              shreg  <= '0;
              bitcnt <= BC_W'(WORD_W-1);
              state  <= S_OUT_CRC;
`else
              state  <= S_DONE;
`endif
            end
          end
          S_WAIT: if (i_word_vld) begin
            shreg      <= i_word;
            bitcnt     <= BC_W'(WORD_W-1);
            words_left <= words_left - CNT_W'(1);
            word_ack   <= 1'b1;
            state      <= S_SHIFT;
          end
          S_SHIFT: if (i_bit_rdy) begin
            shreg  <= shreg << 1;
            bitcnt <= bitcnt - BC_W'(1);
`ifdef ROM_SER_CRC16_EN
            crc    <= crc_nxt;
`endif
            if (last_bit) begin
              if (words_left != '0) begin
                state <= S_WAIT;
              end else begin
`ifdef ROM_SER_CRC16_EN
                // Final CRC must include the bit leaving on this edge.
                shreg  <= ~crc_nxt;
                bitcnt <= BC_W'(WORD_W-1);
                state  <= S_OUT_CRC;
`else
                state  <= S_DONE;
`endif
              end
            end
          end
`ifdef ROM_SER_CRC16_EN
          S_CRC: if (i_bit_rdy) begin
            shreg  <= shreg << 1;
            bitcnt <= bitcnt - BC_W'(1);
            if (last_bit) state <= S_DONE;
          end
`endif
          S_DONE:  state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign o_word_ack = word_ack;
  assign o_bit_vld  = bit_vld;
  assign o_bit      = bit_vld & shreg[WORD_W-1];
  assign o_busy     = (state != S_IDLE);
  assign o_done     = (state == S_DONE);

endmodule

// File: tb/tb_rom_word_serializer.sv
// Scoreboard bench for rom_word_serializer: expected bits queued as words are
// offered, popped as the DUT transfers them. Follows ROM_SER_CRC16_EN if defined.
module tb_rom_word_serializer;

`ifdef ROM_SER_CRC16_EN
  localparam int CRC_BITS = 16;
`else
  localparam int CRC_BITS = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_start = 1'b0;
  logic [3:0]  i_wordcnt = '0;
  logic        i_abort = 1'b0;
  logic [15:0] i_word = '0;
  logic        i_word_vld = 1'b0;
  logic        o_word_ack, o_bit, o_bit_vld, o_busy, o_done;
  logic        i_bit_rdy = 1'b1;
  bit          rdy_tog = 1'b0;

  rom_word_serializer #(.WORD_W(16), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_wordcnt(i_wordcnt),
    .i_abort(i_abort), .i_word(i_word), .i_word_vld(i_word_vld),
    .o_word_ack(o_word_ack), .o_bit(o_bit), .o_bit_vld(o_bit_vld),
    .i_bit_rdy(i_bit_rdy), .o_busy(o_busy), .o_done(o_done)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    i_bit_rdy = rdy_tog ? ~i_bit_rdy : 1'b1;
  end

  // Monitor / scoreboard
  bit          exp_q[$];
  logic [15:0] mcrc;
  int ack_cnt = 0, done_cnt = 0, xfer_cnt = 0, run_len = 0;
  int last_xfer_cyc = 0, done_cyc = 0;
  bit prev_xfer = 0, held_vld = 0;
  logic held_bit = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      prev_xfer = 0;
      held_vld  = 0;
    end else begin
      if (o_word_ack) ack_cnt++;
      if (o_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (held_vld && o_bit_vld) chk("bit_hold", o_bit, held_bit);
      held_vld = o_bit_vld && !i_bit_rdy;
      held_bit = o_bit;
      if (o_bit_vld && i_bit_rdy) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_bit: got %0b want none", o_bit);
        end else begin
          chk("bit", o_bit, exp_q.pop_front());
        end
        xfer_cnt++;
        run_len = prev_xfer ? run_len + 1 : 1;
        last_xfer_cyc = cyc;
        prev_xfer = 1;
      end else begin
        prev_xfer = 0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [15:0] w);
    logic fb;
    for (int i = 15; i >= 0; i--) begin
      exp_q.push_back(w[i]);
      fb   = mcrc[15] ^ w[i];
      mcrc = {mcrc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
  endtask

  task automatic push_crc();
`ifdef ROM_SER_CRC16_EN
    logic [15:0] c;
    c = ~mcrc;
    for (int i = 15; i >= 0; i--) exp_q.push_back(c[i]);
`endif
  endtask

  int start_cyc = 0;
  task automatic start(input logic [3:0] cnt);
    i_wordcnt = cnt;
    i_start   = 1'b1;
    start_cyc = cyc;
    tick(1);
    i_start   = 1'b0;
  endtask

  task automatic feed(input logic [15:0] w, input int dly);
    int t;
    tick(dly);
    i_word = w;
    push_word(w);
    i_word_vld = 1'b1;
    t = 0;
    do begin
      tick(1);
      t++;
    end while (!o_word_ack && t < 200);
    chk("ack_seen", o_word_ack, 1);
    i_word_vld = 1'b0;
  endtask

  task automatic wait_done(input int d0, input string tag);
    int t;
    t = 0;
    while (done_cnt == d0 && t < 1000) begin
      tick(1);
      t++;
    end
    chk({tag, "_done"}, done_cnt, d0 + 1);
  endtask

  task automatic begin_run(output int d0, output int a0, output int x0);
    exp_q.delete();
    mcrc = 16'hFFFF;
    d0 = done_cnt;
    a0 = ack_cnt;
    x0 = xfer_cnt;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int d0, a0, x0;
    tick(2);
    chk("rst_busy", o_busy, 0);
    chk("rst_vld", o_bit_vld, 0);
    chk("rst_bit", o_bit, 0);
    chk("rst_ack", o_word_ack, 0);
    chk("rst_done", o_done, 0);
    rst = 1'b0;
    tick(2);
    chk("idle_busy", o_busy, 0);

    // Single word at full rate
    begin_run(d0, a0, x0);
    fork
      start(4'd1);
      feed(16'hA5C3, 0);
    join
    push_crc();
    wait_done(d0, "t1");
    chk("t1_acks", ack_cnt - a0, 1);
    chk("t1_q_empty", exp_q.size(), 0);
    chk("t1_run", run_len, 16 + CRC_BITS);
    chk("t1_done_lat", done_cyc - last_xfer_cyc, 1);
    tick(2);
    chk("t1_idle", o_busy, 0);

    // All-zero word (CRC tail 0xE2F0 when enabled)
    begin_run(d0, a0, x0);
    fork
      start(4'd1);
      feed(16'h0000, 0);
    join
    push_crc();
    wait_done(d0, "t2");
    chk("t2_acks", ack_cnt - a0, 1);
    chk("t2_q_empty", exp_q.size(), 0);
    chk("t2_xfers", xfer_cnt - x0, 16 + CRC_BITS);
    tick(2);

    // Zero-word transfer
    begin_run(d0, a0, x0);
    push_crc();
    start(4'd0);
    wait_done(d0, "t3");
    chk("t3_acks", ack_cnt - a0, 0);
    chk("t3_xfers", xfer_cnt - x0, CRC_BITS);
    chk("t3_done_lat", done_cyc - start_cyc, 1 + CRC_BITS);
    chk("t3_q_empty", exp_q.size(), 0);
    tick(2);

    // Four words, late word valid, encoder stalling every other cycle
    begin_run(d0, a0, x0);
    rdy_tog = 1'b1;
    fork
      start(4'd4);
      for (int w = 1; w <= 4; w++) feed(16'(w), 3);
    join
    push_crc();
    wait_done(d0, "t4");
    chk("t4_acks", ack_cnt - a0, 4);
    chk("t4_q_empty", exp_q.size(), 0);
    chk("t4_xfers", xfer_cnt - x0, 64 + CRC_BITS);
    rdy_tog = 1'b0;
    tick(3);

    // Abort on 5th bit of word 2, with an ignored start earlier
    begin_run(d0, a0, x0);
    fork
      start(4'd3);
      begin
        feed(16'hBEEF, 0);
        feed(16'h7C01, 0);
      end
      begin : abort_br
        int t;
        t = 0;
        while (xfer_cnt - x0 < 4 && t < 300) begin tick(1); t++; end
        i_wordcnt = 4'd7;
        i_start = 1'b1;
        tick(1);
        i_start = 1'b0;
        t = 0;
        while (xfer_cnt - x0 < 20 && t < 300) begin tick(1); t++; end
        chk("t5_pos", xfer_cnt - x0, 20);
        i_abort = 1'b1;
        tick(1);
        i_abort = 1'b0;
        chk("t5_busy", o_busy, 0);
        chk("t5_vld", o_bit_vld, 0);
        chk("t5_done", o_done, 0);
      end
    join
    tick(5);
    chk("t5_no_done", done_cnt - d0, 0);
    chk("t5_acks", ack_cnt - a0, 2);
    chk("t5_xfers", xfer_cnt - x0, 21);
    exp_q.delete();

    begin_run(d0, a0, x0);
    fork
      start(4'd1);
      feed(16'h1234, 0);
    join
    push_crc();
    wait_done(d0, "t5b");
    chk("t5b_acks", ack_cnt - a0, 1);
    chk("t5b_q_empty", exp_q.size(), 0);
    tick(2);

    // Asynchronous reset mid-shift
    begin_run(d0, a0, x0);
    fork
      start(4'd1);
      feed(16'hFFFF, 0);
    join
    begin : rst_br
      int t;
      t = 0;
      while (xfer_cnt - x0 < 3 && t < 300) begin tick(1); t++; end
    end
    #1;
    rst = 1'b1;
    #1;
    chk("t6_busy", o_busy, 0);
    chk("t6_vld", o_bit_vld, 0);
    chk("t6_bit", o_bit, 0);
    chk("t6_ack", o_word_ack, 0);
    chk("t6_done", o_done, 0);
    tick(1);
    rst = 1'b0;
    exp_q.delete();
    tick(3);
    chk("t6_idle_busy", o_busy, 0);
    chk("t6_idle_vld", o_bit_vld, 0);
    chk("t6_no_done", done_cnt - d0, 0);

    // Recovery run
    begin_run(d0, a0, x0);
    fork
      start(4'd2);
      begin
        feed(16'h8001, 1);
        feed(16'h0F0F, 1);
      end
    join
    push_crc();
    wait_done(d0, "t7");
    chk("t7_acks", ack_cnt - a0, 2);
    chk("t7_q_empty", exp_q.size(), 0);
    tick(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
